// File: rtl/mp_add_pkg.sv
// Shared definitions for the byte-serial multi-precision adder (mp_add_seq).
// Holds the controller state encoding and the slice width.
package mp_add_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/byte_cla_slice.sv
// Combinational 8-bit adder slice with nibble-level carry lookahead.
// Also exports the carry into bit 7 so the caller can form signed overflow.
module byte_cla_slice
   import mp_add_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout,
   output logic              c7
);

   // Returns {c7, cout, sum}; the lower-nibble carry-out is computed from group
   // generate/propagate terms so the upper nibble does not wait on the ripple.
   function automatic logic [BYTE_W+1:0] cla8(input logic [BYTE_W-1:0] x,
                                              input logic [BYTE_W-1:0] y,
                                              input logic            ci);
      logic [BYTE_W-1:0] g;
      logic [BYTE_W-1:0] p;
      logic [BYTE_W:0]   c;
      logic              grp_g;
      logic              grp_p;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < 4; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p[3:0];
      c[4]  = grp_g | (grp_p & ci);
      for (int i = 4; i < BYTE_W; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      cla8 = {c[BYTE_W-1], c[BYTE_W], p ^ c[BYTE_W-1:0]};
   endfunction

   always_comb begin
      {c7, cout, sum} = cla8(a, b, cin);
   end

endmodule

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision add/subtract, one 8-bit slice per clock, LSB first.
// Optional signed-overflow output is enabled by defining MP_ADD_SEQ_OVF_EN.
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int NBYTES = 4
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] a,
   input  logic [BYTE_W*NBYTES-1:0] b,
   input  logic                     sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BYTE_W*NBYTES-1:0] result,
   output logic                     cout,
   output logic                     ovf
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   state_t            state;
   logic [IW-1:0]     idx;
   logic              carry_r;
   logic              sub_r;
   logic [W-1:0]      a_r;
   logic [W-1:0]      b_r;
   logic [W-1:0]      res_r;
   logic              cout_r;
   logic              in_ready_r;
   logic              out_valid_r;

   logic [BYTE_W-1:0] a_byte;
   logic [BYTE_W-1:0] b_byte;
   logic [BYTE_W-1:0] sum_byte;
   logic              slice_cout;
   logic              slice_c7;

   // Subtraction is a + ~b + 1; the +1 enters through carry_r, seeded with sub.
   always_comb begin
      a_byte = a_r[idx*BYTE_W +: BYTE_W];
      b_byte = sub_r ? ~b_r[idx*BYTE_W +: BYTE_W] : b_r[idx*BYTE_W +: BYTE_W];
   end

   byte_cla_slice u_slice (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (carry_r),
      .sum  (sum_byte),
      .cout (slice_cout),
      .c7   (slice_c7)
   );

`ifdef MP_ADD_SEQ_OVF_EN
   logic ovf_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (state == RUN && idx == LAST_IDX) begin
         ovf_r <= slice_c7 ^ slice_cout;
      end
   end

   assign ovf = ovf_r;
`else
   logic unused_c7;
   assign unused_c7 = slice_c7;
   assign ovf       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         carry_r     <= 1'b0;
         res_r       <= '0;
         cout_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  a_r        <= a;
                  b_r        <= b;
                  sub_r      <= sub;
                  carry_r    <= sub;
                  idx        <= '0;
                  in_ready_r <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               res_r[idx*BYTE_W +: BYTE_W] <= sum_byte;
               carry_r                     <= slice_cout;
               if (idx == LAST_IDX) begin
                  cout_r      <= slice_cout;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               // in_ready only rises after the handshake edge; no same-cycle reuse.
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = res_r;
   assign cout      = cout_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq (NBYTES=4); expected ovf follows MP_ADD_SEQ_OVF_EN.
module tb_mp_add_seq;

`ifdef MP_ADD_SEQ_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        cout;
   logic        ovf;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   mp_add_seq #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one request at a negedge, returns at the negedge after the accept edge
   // with scrambled operands so later input changes would corrupt a non-latching DUT.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = ~ta; b = 32'hA5C3_0F96; sub = ~ts;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ovalid_drop"}, 64'(out_valid), 64'd0);
      check({tag, "_iready_rise"}, 64'(in_ready), 64'd1);
   endtask

   task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                     input logic ts, input logic [31:0] er, input logic ec, input logic eo);
      int lat;
      send(ta, tb_v, ts);
      wait_valid(lat);
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_result"}, 64'(result), 64'(er));
      check({tag, "_cout"}, 64'(cout), 64'(ec));
      check({tag, "_ovf"}, 64'(ovf), 64'(eo & OVF_ON));
      consume(tag);
   endtask

   logic [31:0] va [3] = '{32'h1234_5678, 32'h8000_0000, 32'hFFFF_0000};
   logic [31:0] vb [3] = '{32'h1111_1111, 32'h0000_0001, 32'h0001_FFFF};
   logic        vs [3] = '{1'b0, 1'b1, 1'b0};
   logic [31:0] vr [3] = '{32'h2345_6789, 32'h7FFF_FFFF, 32'h0000_FFFF};
   logic        vc [3] = '{1'b0, 1'b1, 1'b1};
   logic        vo [3] = '{1'b0, 1'b1, 1'b0};

   initial begin
      int lat;
      int t [3];
      logic [31:0] held;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);

      op("carry_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      // DONE holds under back-pressure and ignores new requests
      send(32'h0102_0304, 32'h1010_1010, 1'b0);
      wait_valid(lat);
      check("hold_latency", 64'(lat), 64'd4);
      held = result;
      check("hold_result0", 64'(held), 64'h1112_1314);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_result", 64'(result), 64'h1112_1314);
         check("hold_cout", 64'(cout), 64'd0);
      end
      consume("hold");
      @(negedge clk);
      check("hold_no_extra_op", 64'(in_ready), 64'd1);

      // reset on the second RUN cycle
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      check("midrst_cout", 64'(cout), 64'd0);
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) lat++;
      end
      check("midrst_no_pulse", 64'(lat), 64'd0);
      op("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      // back-to-back with in_valid and out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         int n = 0;
         while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         t[i] = cyc;
         a = va[i]; b = vb[i]; sub = vs[i]; in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         a = 32'h5A5A_5A5A; b = 32'h3C3C_3C3C; sub = ~vs[i];
         wait_valid(lat);
         if (i == 2) in_valid = 1'b0;
         check("b2b_latency", 64'(lat), 64'd4);
         check("b2b_result", 64'(result), 64'(vr[i]));
         check("b2b_cout", 64'(cout), 64'(vc[i]));
         check("b2b_ovf", 64'(ovf), 64'(vo[i] & OVF_ON));
         if (i > 0) check("b2b_period", 64'(t[i] - t[i-1]), 64'd6);
      end
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("b2b_idle", 64'(in_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, number of 8-bit slices per operand (legal 1..8).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1, request carries valid operands.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have ports a and b, input, 8*NBYTES each, unsigned/two's-complement operands.
REQ-007 SHALL have port sub, input, 1, 0 = a+b, 1 = a-b.
REQ-008 SHALL have port out_valid, output, 1, result is valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port result, output, 8*NBYTES, sum or difference.
REQ-011 SHALL have port cout, output, 1, final carry (for sub: 1 = no borrow).
REQ-012 SHALL have port ovf, output, 1, signed overflow flag.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 SHALL assert in_ready only in IDLE; accept on the edge where in_valid && in_ready, latching a, b and sub, then entering RUN.
REQ-015 SHALL ignore a, b, sub and in_valid outside the accepting edge.
REQ-016 SHALL, in RUN, process one byte per cycle, LSB first: byte k = a[k] + (sub ? ~b[k] : b[k]) + carry_reg, write into result byte k, update carry_reg with the byte carry-out.
REQ-017 SHALL initialise carry_reg to sub at the accepting edge.
REQ-018 SHALL use a byte index counter of width max(1,$clog2(NBYTES)), reset to 0 on accept, leaving RUN on the edge that processes byte NBYTES-1.
REQ-019 SHALL assert out_valid exactly NBYTES rising edges after the accepting edge.
REQ-020 SHALL hold result, cout, ovf and out_valid stable in DONE while out_ready is low.
REQ-021 SHALL return to IDLE on the edge where out_valid && out_ready; in_ready rises the following cycle (no same-cycle bypass, minimum 1 + NBYTES + 1 cycles per operation).
REQ-022 SHALL drive cout = carry_reg after the last byte; arithmetic wraps modulo 2^(8*NBYTES).
REQ-023 SHALL keep result, cout and ovf at last completed values in IDLE (undefined contents not allowed).

Reset
REQ-024 SHALL, on rst, enter IDLE, clear byte index, carry_reg, result, cout and ovf to 0, and drive out_valid=0, in_ready=1 the next cycle.
REQ-025 SHALL, on rst during RUN or DONE, discard the in-flight operation with no out_valid pulse.
REQ-026 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-027 SHALL use macro MP_ADD_SEQ_OVF_EN.
REQ-028 SHALL, with MP_ADD_SEQ_OVF_EN defined, set ovf = carry into MSB XOR carry out of MSB of the top byte, registered with result.
REQ-029 SHALL, without MP_ADD_SEQ_OVF_EN, tie ovf to 0 and contain no overflow logic.

Structure
REQ-030 SHALL place FSM state enum (IDLE, RUN, DONE) and constant BYTE_W = 8 in shared package mp_add_pkg.
REQ-031 SHALL instantiate one combinational sub-module byte_cla_slice (8-bit lookahead slice: a, b, cin -> sum, cout, c7 into MSB) for the per-byte addition.

Verification
REQ-032 SHALL cover: NBYTES=4, a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0x00000000, cout=1, ovf=0, out_valid 4 edges after accept.
REQ-033 SHALL cover: a=0x00000005, b=0x00000007, sub=1 -> result=0xFFFFFFFE, cout=0, ovf=0.
REQ-034 SHALL cover: a=0x7FFFFFFF, b=0x00000001, sub=0 -> result=0x80000000, ovf=1 with macro, ovf=0 without.
REQ-035 SHALL cover: out_ready held low 3 cycles in DONE -> result/cout/out_valid unchanged, in_ready=0, in_valid pulses ignored.
REQ-036 SHALL cover: rst asserted on second RUN cycle -> next cycle in_ready=1, out_valid=0, result=0; following request completes correctly.
REQ-037 SHALL cover: back-to-back requests with out_ready=1 and in_valid constant -> one accept every NBYTES+2 cycles, each result correct.
